decode_stage: RTL

- ID stage of the in-order pipeline. Takes the instruction from the IF/ID register and decodes its opcode.
- Drives the immediate-select and raw immediate field into the immediate extender, and takes the 32-bit sign-extended result back.
- Registers the decoded fields, control and extended immediate into the ID/EX pipeline register.
- Owns load-use hazard detection (bubble insertion plus upstream stall), downstream stall hold and branch flush.

---
 rtl/decode_stage_if.sv | 53 +++++
 rtl/decode_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - IF/ID, extender and ID/EX signal bundle for decode_stage
//
// Purpose: groups every non-clock signal of the decode stage.
//   slave  : the decode stage itself
//   master : the surrounding pipeline (IF/ID register, immediate extender, EX stage)
// Signals:
//   if_valid, if_instr, if_pc  IF/ID register contents
//   id_ready                   decode accepts the current instruction (0 stalls IF)
//   immsrc, imm                immediate-select and raw field to the extender
//   immext                     sign-extended immediate returned by the extender
//   ex_stall, ex_flush         EX back-pressure and taken-branch kill
//   ex_*                       registered ID/EX pipeline contents
interface decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  if_valid;
  logic [31:0]           if_instr;
  logic [XLEN-1:0]       if_pc;
  logic                  id_ready;
  logic [2:0]            immsrc;
  logic [24:0]           imm;
  logic [31:0]           immext;
  logic                  ex_stall;
  logic                  ex_flush;
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [31:0]           ex_immext;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  ex_alusrc;
  logic                  ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, immext, ex_stall, ex_flush,
    output id_ready, immsrc, imm,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_immext,
    output ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_alusrc, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, immext, ex_stall, ex_flush,
    input  id_ready, immsrc, imm,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_immext,
    input  ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_alusrc, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: opcode decode, load-use hazard, ID/EX register
//
// Purpose: decodes the IF/ID instruction, hands the immediate field to the
// extender, and registers fields, control and extended immediate into ID/EX.
// Handles load-use bubbles, EX stall hold and branch flush.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    decode_stage_if.slave (IF/ID inputs, extender link, ID/EX outputs)
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Control bundle order: {regwrite, memread, memwrite, branch, jump, alusrc, illegal}
  localparam int CTL_W = 7;

  logic [6:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [2:0]            w_immsrc;
  logic                  w_regwrite;
  logic                  w_memread;
  logic                  w_memwrite;
  logic                  w_branch;
  logic                  w_jump;
  logic                  w_alusrc;
  logic                  w_illegal;
  logic                  w_use_rs1;
  logic                  w_use_rs2;
  logic [CTL_W-1:0]      w_ctl;
  logic                  w_hazard;

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [31:0]           r_immext;
  logic [CTL_W-1:0]      r_ctl;

  assign w_opcode = bus.if_instr[6:0];
  assign w_rd     = bus.if_instr[7  +: REG_ADDR_W];
  assign w_rs1    = bus.if_instr[15 +: REG_ADDR_W];
  assign w_rs2    = bus.if_instr[20 +: REG_ADDR_W];

  always_comb begin
    w_immsrc   = 3'b000;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_alusrc   = 1'b1;
    w_illegal  = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b0;
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
      end
      OP_IMM: begin
        w_regwrite = 1'b1;
        w_use_rs1  = 1'b1;
      end
      OP_LOAD: begin
        w_regwrite = 1'b1;
        w_memread  = 1'b1;
        w_use_rs1  = 1'b1;
      end
      OP_JALR: begin
        w_regwrite = 1'b1;
        w_jump     = 1'b1;
        w_use_rs1  = 1'b1;
      end
      OP_STORE: begin
        w_immsrc   = 3'b001;
        w_memwrite = 1'b1;
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
      end
      OP_BRANCH: begin
        w_immsrc   = 3'b010;
        w_branch   = 1'b1;
        w_alusrc   = 1'b0;
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
      end
      OP_JAL: begin
        w_immsrc   = 3'b011;
        w_regwrite = 1'b1;
        w_jump     = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_immsrc   = 3'b100;
        w_regwrite = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_ctl = {w_regwrite, w_memread, w_memwrite, w_branch, w_jump, w_alusrc, w_illegal};

  // A load in EX whose destination is a source this instruction actually reads.
  // x0 never creates a dependency.
  assign w_hazard = bus.if_valid && r_valid && r_ctl[5] && (r_rd != '0) &&
                    ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_rs2 && (w_rs2 == r_rd)));

  // Flush wins over stall: the killed IF/ID slot must not be held back.
  assign bus.id_ready = bus.ex_flush || (!bus.ex_stall && !w_hazard);
  assign bus.immsrc   = w_immsrc;
  assign bus.imm      = bus.if_instr[31:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_immext <= '0;
      r_ctl    <= '0;
    end else if (bus.ex_flush) begin
      r_valid <= 1'b0;
      r_ctl   <= '0;
    end else if (bus.ex_stall) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      // Bubble: data fields are left as-is, only valid/control matter.
      r_valid <= 1'b0;
      r_ctl   <= '0;
    end else begin
      r_valid  <= bus.if_valid;
      r_pc     <= bus.if_pc;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_rd     <= w_rd;
      r_immext <= bus.immext;
      r_ctl    <= bus.if_valid ? w_ctl : '0;
    end
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_pc       = r_pc;
  assign bus.ex_rs1      = r_rs1;
  assign bus.ex_rs2      = r_rs2;
  assign bus.ex_rd       = r_rd;
  assign bus.ex_immext   = r_immext;
  assign bus.ex_regwrite = r_ctl[6];
  assign bus.ex_memread  = r_ctl[5];
  assign bus.ex_memwrite = r_ctl[4];
  assign bus.ex_branch   = r_ctl[3];
  assign bus.ex_jump     = r_ctl[2];
  assign bus.ex_alusrc   = r_ctl[1];
  assign bus.ex_illegal  = r_ctl[0];

endmodule
